rv_imem_fetch: RTL and testbench



---
 rtl/rv_imem_pkg.sv | 26 ++
 rtl/rv_imem_resp_fifo.sv | 61 ++++++
 rtl/rv_imem_fetch.sv | 99 +++++++++
 tb/tb_rv_imem_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_imem_pkg.sv
// ---------------------------------------------------------------------------
// rv_imem_pkg : shared types, constants and fault check for rv_imem_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv_imem_pkg;

  localparam int unsigned XLEN_C      = 32;
  localparam int unsigned ADDR_W_C    = 32;
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_C-1:0]   instr;
    logic                fault;
    logic [ADDR_W_C-1:0] addr;
  } imem_resp_t;

  // Address is zero-extended to 64 bits so one check serves any ADDR_W up to 64.
  function automatic logic imem_fault_chk(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_imem_resp_fifo.sv
// ---------------------------------------------------------------------------
// rv_imem_resp_fifo : 2-entry response FIFO with occupancy count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv_imem_resp_fifo
  import rv_imem_pkg::*;
#(
  parameter type T = imem_resp_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  T           push_data_i,
  input  logic       pop_i,
  output T           head_o,
  output logic [1:0] count_o
);

  T           entry_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Entries are cleared on reset so the head never presents X.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (push_i) begin
        entry_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/rv_imem_fetch.sv
// ---------------------------------------------------------------------------
// rv_imem_fetch : synchronous instruction memory with valid/ready fetch channels
// Optional write port enabled by macro RV_IMEM_WRITE_PORT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv_imem_fetch
  import rv_imem_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      DEPTH     = 1024,
  parameter int unsigned      ADDR_W    = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_C)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_instr_o,
  output logic              resp_fault_o,
`ifdef RV_IMEM_WRITE_PORT_EN
  input  logic              imem_we_i,
  input  logic [ADDR_W-1:0] imem_waddr_i,
  input  logic [XLEN-1:0]   imem_wdata_i,
`endif
  output logic [ADDR_W-1:0] resp_addr_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic              fault;
    logic [ADDR_W-1:0] addr;
  } resp_t;

  logic [XLEN-1:0] imem [DEPTH];

  logic [1:0]      fifo_count;
  logic            push;
  logic            pop;
  logic            req_fault;
  logic [IDX_W-1:0] req_idx;
  resp_t           push_data;
  resp_t           head;

  assign req_ready_o  = (fifo_count != 2'd2);
  assign resp_valid_o = (fifo_count != 2'd0);
  assign push         = req_valid_i && req_ready_o;
  assign pop          = resp_valid_o && resp_ready_i;

  assign req_fault = imem_fault_chk(64'(req_addr_i), DEPTH);
  assign req_idx   = req_addr_i[IDX_W+1:2];

  // The array read feeds the FIFO tail register directly: one-cycle synchronous read.
  always_comb begin
    push_data       = '0;
    push_data.fault = req_fault;
    push_data.addr  = req_addr_i;
    push_data.instr = req_fault ? NOP_INSTR : imem[req_idx];
  end

`ifdef RV_IMEM_WRITE_PORT_EN
  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;

  assign wr_ok  = imem_we_i && !imem_fault_chk(64'(imem_waddr_i), DEPTH);
  assign wr_idx = imem_waddr_i[IDX_W+1:2];

  // Non-blocking update leaves the same-edge read seeing the old word.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      imem[wr_idx] <= imem_wdata_i;
    end
  end
`endif

  rv_imem_resp_fifo #(
    .T (resp_t)
  ) u_resp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign resp_instr_o = head.instr;
  assign resp_fault_o = head.fault;
  assign resp_addr_o  = head.addr;

endmodule

`default_nettype wire

// File: tb/tb_rv_imem_fetch.sv
// ---------------------------------------------------------------------------
// tb_rv_imem_fetch : scoreboard bench for rv_imem_fetch with a reference memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rv_imem_fetch;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_instr_o;
  logic        resp_fault_o;
  logic [31:0] resp_addr_o;
`ifdef RV_IMEM_WRITE_PORT_EN
  logic        imem_we_i;
  logic [31:0] imem_waddr_i;
  logic [31:0] imem_wdata_i;
`endif

  rv_imem_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_instr_o (resp_instr_o),
    .resp_fault_o (resp_fault_o),
`ifdef RV_IMEM_WRITE_PORT_EN
    .imem_we_i    (imem_we_i),
    .imem_waddr_i (imem_waddr_i),
    .imem_wdata_i (imem_wdata_i),
`endif
    .resp_addr_o  (resp_addr_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tb_mem [DEPTH];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_push   = 0;
  int          n_pop    = 0;
  int          exp_cnt  = 0;
  bit          w_we     = 1'b0;
  logic [31:0] w_addr   = '0;
  logic [31:0] w_data   = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic bit model_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  // One cycle: apply inputs at negedge, predict acceptance from the model's occupancy.
  task automatic drive(input bit v, input logic [31:0] a, input bit rr, output bit acc);
    exp_t e;
    @(negedge clk);
    req_valid_i  = v;
    req_addr_i   = a;
    resp_ready_i = rr;
`ifdef RV_IMEM_WRITE_PORT_EN
    imem_we_i    = w_we;
    imem_waddr_i = w_addr;
    imem_wdata_i = w_data;
`endif
    #1;
    exp_cnt = n_push - n_pop;
    chk("req_ready", req_ready_o, exp_cnt != 2);
    acc = v && (exp_cnt != 2);
    if (acc) begin
      e.fault = model_fault(a);
      e.addr  = a;
      e.instr = e.fault ? NOP : tb_mem[a / 4];
      sb.push_back(e);
      n_push++;
    end
`ifdef RV_IMEM_WRITE_PORT_EN
    if (w_we && !model_fault(w_addr)) tb_mem[w_addr / 4] = w_data;
`endif
  endtask

  task automatic issue(input logic [31:0] a, input bit rr);
    bit acc;
    int tries = 0;
    do begin
      drive(1'b1, a, rr, acc);
      tries++;
    end while (!acc && tries < 20);
    if (!acc) begin
      n_checks++;
      $display("FAIL issue_timeout: addr %0h never accepted", a);
    end
  endtask

  task automatic idle(input int n, input bit rr);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, rr, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    sb.delete();
    n_push  = 0;
    n_pop   = 0;
    exp_cnt = 0;
    #1;
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_resp_instr", resp_instr_o, 0);
    chk("rst_resp_fault", resp_fault_o, 0);
    chk("rst_resp_addr", resp_addr_o, 0);
  endtask

  // Monitor: compares the FIFO head to the oldest expectation, pops on handshake.
  initial begin
    exp_t tmp;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        chk("resp_valid", resp_valid_o, exp_cnt != 0);
        if (resp_valid_o) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got instr %0h with empty scoreboard", resp_instr_o);
          end else begin
            chk("resp_instr", resp_instr_o, sb[0].instr);
            chk("resp_fault", resp_fault_o, sb[0].fault);
            chk("resp_addr", resp_addr_o, sb[0].addr);
            if (resp_ready_i) begin
              tmp = sb.pop_front();
              n_pop++;
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    logic [31:0] a;
    int          r;

    reset        = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    resp_ready_i = 1'b0;
`ifdef RV_IMEM_WRITE_PORT_EN
    imem_we_i    = 1'b0;
    imem_waddr_i = '0;
    imem_wdata_i = '0;
`endif
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = $urandom();
    tb_mem[0] = 32'h00500093;
    tb_mem[1] = 32'h00a00113;
    tb_mem[2] = 32'h002081b3;
    tb_mem[3] = 32'h00000013;
    for (int i = 0; i < DEPTH; i++) dut.imem[i] = tb_mem[i];

    repeat (3) @(negedge clk);
    do_reset();

    // Back-to-back stream
    issue(32'h0, 1'b1);
    issue(32'h4, 1'b1);
    issue(32'h8, 1'b1);
    issue(32'hC, 1'b1);
    idle(3, 1'b1);

    // Backpressure: third request stalls until the consumer drains
    issue(32'h0, 1'b0);
    issue(32'h4, 1'b0);
    drive(1'b1, 32'h8, 1'b0, acc);
    chk("bp_third_blocked", acc, 0);
    drive(1'b1, 32'h8, 1'b0, acc);
    issue(32'h8, 1'b1);
    idle(4, 1'b1);

    // Faults
    issue(32'h2, 1'b1);
    issue(32'h1000, 1'b1);
    idle(3, 1'b1);

    // Reset with two buffered responses
    issue(32'h0, 1'b0);
    issue(32'h4, 1'b0);
    do_reset();
    issue(32'h4, 1'b1);
    idle(3, 1'b1);

`ifdef RV_IMEM_WRITE_PORT_EN
    w_we = 1'b1; w_addr = 32'h8; w_data = 32'hDEADBEEF;
    issue(32'h8, 1'b1);
    w_we = 1'b0;
    idle(2, 1'b1);
    issue(32'h8, 1'b1);
    w_we = 1'b1; w_addr = 32'h9; w_data = 32'h12345678;
    idle(1, 1'b1);
    w_we = 1'b0;
    issue(32'h8, 1'b1);
    idle(3, 1'b1);
`endif

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (r == 7)      a = a + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000)) * 4;
      else if (r == 9) a = $urandom();
`ifdef RV_IMEM_WRITE_PORT_EN
      w_we   = ($urandom_range(0, 3) == 0);
      w_addr = ($urandom_range(0, 4) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH - 1)) * 4;
      w_data = $urandom();
`endif
      drive(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 2) != 0), acc);
    end
    w_we = 1'b0;
    idle(6, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
